// File: rtl/seg7_pkg.sv
// Shared register map, CTRL field layout and hex-to-segment decode for the
// multi-digit seven-segment display controller.
package seg7_pkg;

   localparam logic [3:0] ADDR_CTRL     = 4'd0;
   localparam logic [3:0] ADDR_DATA     = 4'd1;
   localparam logic [3:0] ADDR_RAW_BASE = 4'd2;
   localparam logic [3:0] ADDR_STATUS   = 4'd10;

   localparam int CTRL_DECODE_LSB  = 0;
   localparam int CTRL_ENABLE_LSB  = 8;
   localparam int CTRL_BLINK_LSB   = 16;
   localparam int CTRL_RESTART_BIT = 31;

   localparam int MAX_DIGITS = 8;

   // Active-high gfedcba pattern, bit 0 = segment a.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] seg;
      seg = 7'h00;
      case (nibble)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_blink_timer.sv
// Free-running blink timer: blink_phase toggles every BLINK_DIV clocks and
// a restart forces the on half with a fresh period.
module seg7_blink_timer #(
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic blink_phase
);

   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

   logic [CNT_W-1:0] count;

   // Restart takes priority over a wrap landing on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count       <= '0;
         blink_phase <= 1'b1;
      end else if (restart) begin
         count       <= '0;
         blink_phase <= 1'b1;
      end else if (count == CNT_MAX) begin
         count       <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Avalon-MM slave driving up to 8 seven-segment digits with per-digit hex
// decode or raw patterns, enable and hardware blink.
module seg7_display_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int BLINK_DIV  = 25_000_000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [3:0]              address,
   input  logic                    chipselect,
   input  logic                    write_n,
   input  logic [31:0]             writedata,
   output logic [31:0]             readdata,
   output logic [7*NUM_DIGITS-1:0] seg_out,
   output logic                    blink_phase
);

   localparam int SEG_W = 7 * NUM_DIGITS;
   localparam logic [SEG_W-1:0] SEG_POLARITY = {SEG_W{ACTIVE_LOW}};

   logic [NUM_DIGITS-1:0]   decode_mask;
   logic [NUM_DIGITS-1:0]   enable_mask;
   logic [NUM_DIGITS-1:0]   blink_mask;
   logic [4*NUM_DIGITS-1:0] digit_data;
   logic [6:0]              raw_seg [NUM_DIGITS];

   logic                    wr_en;
   logic                    ctrl_wr;
   logic                    data_wr;
   logic                    raw_wr;
   logic                    raw_hit;
   logic [3:0]              raw_idx;
   logic                    restart;
   logic [SEG_W-1:0]        seg_active;
   logic                    unused_wdata;

   assign wr_en   = chipselect && !write_n;
   assign raw_idx = address - ADDR_RAW_BASE;
   assign raw_hit = (address >= ADDR_RAW_BASE) && (int'(raw_idx) < NUM_DIGITS);
   assign ctrl_wr = wr_en && (address == ADDR_CTRL);
   assign data_wr = wr_en && (address == ADDR_DATA);
   assign raw_wr  = wr_en && raw_hit;
   assign restart = ctrl_wr && writedata[CTRL_RESTART_BIT];
   assign unused_wdata = ^{1'b0, writedata};

   seg7_blink_timer #(
      .BLINK_DIV   (BLINK_DIV)
   ) u_blink_timer (
      .clk         (clk),
      .reset_n     (reset_n),
      .restart     (restart),
      .blink_phase (blink_phase)
   );

   // Register file; mask bits above NUM_DIGITS simply have no storage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         decode_mask <= '1;
         enable_mask <= '0;
         blink_mask  <= '0;
         digit_data  <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            raw_seg[i] <= '0;
         end
      end else begin
         if (ctrl_wr) begin
            decode_mask <= writedata[CTRL_DECODE_LSB +: NUM_DIGITS];
            enable_mask <= writedata[CTRL_ENABLE_LSB +: NUM_DIGITS];
            blink_mask  <= writedata[CTRL_BLINK_LSB +: NUM_DIGITS];
         end
         if (data_wr) begin
            digit_data <= writedata[4*NUM_DIGITS-1:0];
         end
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (raw_wr && (raw_idx == 4'(i))) begin
               raw_seg[i] <= writedata[6:0];
            end
         end
      end
   end

   always_comb begin
      readdata = '0;
      if (address == ADDR_CTRL) begin
         readdata[CTRL_DECODE_LSB +: NUM_DIGITS] = decode_mask;
         readdata[CTRL_ENABLE_LSB +: NUM_DIGITS] = enable_mask;
         readdata[CTRL_BLINK_LSB +: NUM_DIGITS]  = blink_mask;
      end else if (address == ADDR_DATA) begin
         readdata[4*NUM_DIGITS-1:0] = digit_data;
      end else if (address == ADDR_STATUS) begin
         readdata[0] = blink_phase;
      end else if (raw_hit) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (raw_idx == 4'(i)) begin
               readdata[6:0] = raw_seg[i];
            end
         end
      end
   end

   // Blanking (disabled or blink off-half) overrides both decode and raw.
   always_comb begin
      seg_active = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!enable_mask[i] || (blink_mask[i] && !blink_phase)) begin
            seg_active[7*i +: 7] = 7'h00;
         end else if (decode_mask[i]) begin
            seg_active[7*i +: 7] = hex_to_seg(digit_data[4*i +: 4]);
         end else begin
            seg_active[7*i +: 7] = raw_seg[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg_out <= SEG_POLARITY;
      end else begin
         seg_out <= seg_active ^ SEG_POLARITY;
      end
   end

endmodule
